// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping bus controller: bus op codes, MESI codes and
// the controller state encoding.
package snoop_pkg;

  typedef enum logic [1:0] {
    OpNone       = 2'b00,
    OpReadMiss   = 2'b01,
    OpWriteMiss  = 2'b10,
    OpInvalidate = 2'b11
  } bus_op_e;

  typedef enum logic [1:0] {
    MesiInvalid   = 2'b00,
    MesiShared    = 2'b01,
    MesiExclusive = 2'b10,
    MesiModified  = 2'b11
  } mesi_e;

  typedef enum logic [2:0] {
    StIdle,
    StBcast,
    StSnoop,
    StWb,
    StMem,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester at or after
// the pointer, wrapping around.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    elig_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

  always_comb begin
    logic [IdxW-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IdxW'((32'(ptr_i) + k) % N);
      if (!any_o && elig_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// Snooping bus owner: round-robin grant, broadcast, snoop-response collection, then
// either a snooper writeback or a memory access before completing to the requester.
module snoop_bus_controller
  import snoop_pkg::*;
#(
  parameter int unsigned NUM_CACHES = 4,
  parameter int unsigned ADDR_W     = 8,
  localparam int unsigned IdxW      = $clog2(NUM_CACHES)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_CACHES-1:0]      req,
  input  logic [2*NUM_CACHES-1:0]    req_op,
  input  logic [ADDR_W*NUM_CACHES-1:0] req_addr,
  input  logic [NUM_CACHES-1:0]      snoop_shared,
  input  logic [NUM_CACHES-1:0]      snoop_abort,
  input  logic                       wb_done,
  input  logic                       mem_ready,
  output logic [NUM_CACHES-1:0]      gnt,
  output logic                       bus_valid,
  output logic [1:0]                 bus_op,
  output logic [ADDR_W-1:0]          bus_addr,
  output logic [IdxW-1:0]            bus_src,
  output logic                       mem_req,
  output logic [NUM_CACHES-1:0]      done,
  output logic                       done_shared,
  output logic                       protocol_err
);

  ctrl_state_e             state_q, state_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [NUM_CACHES-1:0]   gnt_q, gnt_d;
  logic                    bus_valid_q, bus_valid_d;
  bus_op_e                 bus_op_q, bus_op_d;
  logic [ADDR_W-1:0]       bus_addr_q, bus_addr_d;
  logic [IdxW-1:0]         bus_src_q, bus_src_d;
  logic                    mem_req_q, mem_req_d;
  logic [NUM_CACHES-1:0]   done_q, done_d;
  logic                    done_shared_q, done_shared_d;
  logic                    err_q, err_d;
  logic                    shared_any_q, shared_any_d;

  logic [NUM_CACHES-1:0]   elig, arb_gnt, abort_m, shared_m;
  logic [IdxW-1:0]         arb_idx;
  logic                    arb_any, multi_abort;
  logic [1:0]              op_sel;
  logic [ADDR_W-1:0]       addr_sel;

  always_comb begin
    elig     = '0;
    op_sel   = '0;
    addr_sel = '0;
    for (int unsigned i = 0; i < NUM_CACHES; i++) begin
      elig[i] = req[i] && (req_op[2*i +: 2] != OpNone);
      if (arb_idx == IdxW'(i)) begin
        op_sel   = req_op[2*i +: 2];
        addr_sel = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  rr_arbiter #(
    .N (NUM_CACHES)
  ) u_arb (
    .elig_i (elig),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (arb_gnt),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  // The owner's own snoop lines are not meaningful responses.
  assign abort_m     = snoop_abort & ~gnt_q;
  assign shared_m    = snoop_shared & ~gnt_q;
  assign multi_abort = |(abort_m & (abort_m - NUM_CACHES'(1)));

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    bus_valid_d   = 1'b0;
    bus_op_d      = bus_op_q;
    bus_addr_d    = bus_addr_q;
    bus_src_d     = bus_src_q;
    mem_req_d     = 1'b0;
    done_d        = '0;
    done_shared_d = 1'b0;
    err_d         = err_q;
    shared_any_d  = shared_any_q;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          state_d     = StBcast;
          gnt_d       = arb_gnt;
          bus_src_d   = arb_idx;
          bus_op_d    = bus_op_e'(op_sel);
          bus_addr_d  = addr_sel;
          bus_valid_d = 1'b1;
        end
      end
      StBcast: state_d = StSnoop;
      StSnoop: begin
        shared_any_d = |shared_m;
        if (bus_op_q == OpInvalidate) begin
          if (|abort_m) err_d = 1'b1;
          state_d = StDone;
          done_d  = gnt_q;
        end else if (|abort_m) begin
          if (multi_abort) err_d = 1'b1;
          state_d = StWb;
        end else begin
          state_d   = StMem;
          mem_req_d = 1'b1;
        end
      end
      StWb: begin
        if (wb_done) begin
          state_d       = StDone;
          done_d        = gnt_q;
          done_shared_d = (bus_op_q == OpReadMiss) && shared_any_q;
        end
      end
      StMem: begin
        mem_req_d = 1'b1;
        if (mem_ready) begin
          mem_req_d     = 1'b0;
          state_d       = StDone;
          done_d        = gnt_q;
          done_shared_d = (bus_op_q == OpReadMiss) && shared_any_q;
        end
      end
      StDone: begin
        state_d  = StIdle;
        gnt_d    = '0;
        bus_op_d = OpNone;
        rr_ptr_d = (bus_src_q == IdxW'(NUM_CACHES - 1)) ? '0 : bus_src_q + IdxW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      gnt_q         <= '0;
      bus_valid_q   <= 1'b0;
      bus_op_q      <= OpNone;
      bus_addr_q    <= '0;
      bus_src_q     <= '0;
      mem_req_q     <= 1'b0;
      done_q        <= '0;
      done_shared_q <= 1'b0;
      err_q         <= 1'b0;
      shared_any_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      bus_valid_q   <= bus_valid_d;
      bus_op_q      <= bus_op_d;
      bus_addr_q    <= bus_addr_d;
      bus_src_q     <= bus_src_d;
      mem_req_q     <= mem_req_d;
      done_q        <= done_d;
      done_shared_q <= done_shared_d;
      err_q         <= err_d;
      shared_any_q  <= shared_any_d;
    end
  end

  assign gnt          = gnt_q;
  assign bus_valid    = bus_valid_q;
  assign bus_op       = bus_op_q;
  assign bus_addr     = bus_addr_q;
  assign bus_src      = bus_src_q;
  assign mem_req      = mem_req_q;
  assign done         = done_q;
  assign done_shared  = done_shared_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Scoreboard bench for snoop_bus_controller: bench-side caches, snoopers and memory,
// with expected broadcasts and completions queued from a rule-level model.
module tb_snoop_bus_controller;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int PMem = 1, PWb = 2, PInv = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  req_op = '0;
  logic [AW*N-1:0] req_addr = '0;
  logic [N-1:0]    snoop_shared = '0, snoop_abort = '0;
  logic            wb_done = 1'b0, mem_ready = 1'b0;
  logic [N-1:0]    gnt, done;
  logic            bus_valid, mem_req, done_shared, protocol_err;
  logic [1:0]      bus_op, bus_src;
  logic [AW-1:0]   bus_addr;

  snoop_bus_controller #(
    .NUM_CACHES (N),
    .ADDR_W     (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .snoop_shared (snoop_shared),
    .snoop_abort  (snoop_abort),
    .wb_done      (wb_done),
    .mem_ready    (mem_ready),
    .gnt          (gnt),
    .bus_valid    (bus_valid),
    .bus_op       (bus_op),
    .bus_addr     (bus_addr),
    .bus_src      (bus_src),
    .mem_req      (mem_req),
    .done         (done),
    .done_shared  (done_shared),
    .protocol_err (protocol_err)
  );

  always #5 clock = ~clock;

  typedef struct {int idx; int op; int addr;} bc_t;
  typedef struct {int idx; bit shared; int path; bit err;} dn_t;

  bc_t bq[$];
  dn_t dq[$];
  int  done_log[$];
  int  total = 0, bad = 0, cyc = 0, bv_cnt = 0, t_bv = 0;
  int  m_ptr = 0, cur_idx = 0, phase = 0, path_c = 0, wb_cnt = -1, mem_cnt = -1;
  bit  m_err = 0, inflight = 0, rand_en = 0, snoop_rand = 0, mem_hold = 0;
  logic [N-1:0] dir_shared = '0, dir_abort = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  function automatic logic [N-1:0] rand_abort();
    logic [N-1:0] v = '0;
    int r = $urandom_range(0, 9);
    if (r >= 6) v[$urandom_range(0, N-1)] = 1'b1;
    if (r == 9) v[$urandom_range(0, N-1)] = 1'b1;
    return v;
  endfunction

  // Rule-level model: first eligible requester from the pointer, then snoop outcome.
  task automatic predict();
    int w = -1, j, op_i;
    logic [N-1:0] own = '0, sh, ab, am, sm;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (w < 0 && req[j] && req_op[2*j +: 2] != 2'b00) w = j;
    end
    if (w < 0) begin
      bq.push_back('{-1, 0, 0});
      return;
    end
    op_i = int'(req_op[2*w +: 2]);
    bq.push_back('{w, op_i, int'(req_addr[AW*w +: AW])});
    m_ptr    = (w + 1) % N;
    cur_idx  = w;
    inflight = 1;
    own[w]   = 1'b1;
    sh = snoop_rand ? N'($urandom) : dir_shared;
    ab = snoop_rand ? rand_abort() : dir_abort;
    snoop_shared = sh;
    snoop_abort  = ab;
    am = ab & ~own;
    sm = sh & ~own;
    if (op_i == 3) begin
      path_c = PInv;
      if (am != 0) m_err = 1;
    end else if (am != 0) begin
      path_c = PWb;
      if ($countones(am) > 1) m_err = 1;
    end else begin
      path_c = PMem;
    end
    dq.push_back('{w, (op_i == 1) && (sm != 0), path_c, m_err});
    phase = 1;
  endtask

  task automatic gen_requests();
    for (int i = 0; i < N; i++) begin
      if (!req[i] && !(inflight && i == cur_idx)) begin
        if ($urandom_range(0, 3) == 0) begin
          req_op[2*i +: 2]    = 2'($urandom_range(0, 3));
          req_addr[AW*i +: AW] = AW'($urandom);
          req[i] = 1'b1;
        end
      end else if (req[i] && req_op[2*i +: 2] == 2'b00 && $urandom_range(0, 3) == 0) begin
        req[i] = 1'b0;
      end
    end
  endtask

  // Caches, snoopers and memory, acting just after each rising edge.
  initial forever begin
    @(posedge clock);
    #1;
    mem_ready = 1'b0;
    wb_done   = 1'b0;
    if (reset) begin
      phase = 0; inflight = 0; wb_cnt = -1; mem_cnt = -1;
      snoop_shared = '0; snoop_abort = '0;
      continue;
    end
    for (int i = 0; i < N; i++) begin
      if (done[i]) begin
        req[i]   = 1'b0;
        inflight = 0;
      end
    end
    if (phase == 1) begin
      phase = 2;
      if (rand_en && $urandom_range(0, 7) == 0) req[cur_idx] = 1'b0;
    end else if (phase == 2) begin
      snoop_shared = '0;
      snoop_abort  = '0;
      phase = 0;
      if (path_c == PWb) wb_cnt = $urandom_range(0, 3);
    end else if (bus_valid) begin
      predict();
    end
    if (wb_cnt >= 0) begin
      if (wb_cnt == 0) wb_done = 1'b1;
      wb_cnt--;
    end
    if (mem_req && !mem_hold) begin
      if (mem_cnt < 0) mem_cnt = $urandom_range(0, 3);
      if (mem_cnt == 0) mem_ready = 1'b1;
      mem_cnt--;
    end else if (!mem_req && rand_en && $urandom_range(0, 7) == 0) begin
      mem_ready = 1'b1;
    end
    if (rand_en) gen_requests();
  end

  // Monitor: pops and compares whenever the DUT presents a broadcast or completion.
  initial begin
    bc_t e;
    dn_t d;
    forever begin
      @(negedge clock);
      if (reset) continue;
      if (bus_valid) begin
        bv_cnt++;
        t_bv = cyc;
        if (bq.size() == 0) chk("bcast_unexpected", 1, 0);
        else begin
          e = bq.pop_front();
          chk("bus_src", bus_src, e.idx);
          chk("bus_op", bus_op, e.op);
          chk("bus_addr", bus_addr, e.addr);
          chk("gnt", gnt, 1 << e.idx);
        end
      end
      if (done != 0) begin
        done_log.push_back(cyc);
        if (dq.size() == 0) chk("done_unexpected", done, 0);
        else begin
          d = dq.pop_front();
          chk("done", done, 1 << d.idx);
          chk("done_shared", done_shared, d.shared);
          chk("protocol_err", protocol_err, d.err);
          if (d.path == PInv) chk("inv_latency", cyc - t_bv, 2);
        end
      end
      if (mem_req) chk("mem_req_path", (dq.size() > 0) ? dq[0].path : 0, PMem);
      if (gnt == 0) chk("idle_bus_op", bus_op, 0);
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_bus_valid"}, bus_valid, 0);
    chk({tag, "_bus_op"}, bus_op, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_src"}, bus_src, 0);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_shared"}, done_shared, 0);
    chk({tag, "_protocol_err"}, protocol_err, 0);
  endtask

  task automatic set_req(input int i, input int op, input int addr);
    req_op[2*i +: 2]     = 2'(op);
    req_addr[AW*i +: AW] = AW'(addr);
    req[i] = 1'b1;
  endtask

  task automatic wait_quiet(input string name, input int max);
    int n = 0;
    while (n < max && (req != 0 || inflight || dq.size() != 0 || bq.size() != 0)) begin
      @(negedge clock);
      n++;
    end
    chk(name, n < max, 1);
    @(posedge clock);
    #2;
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clock);
    #2;
    reset = 1'b1;
    req   = '0;
    repeat (cycles) @(posedge clock);
    #2;
    bq.delete(); dq.delete();
    m_ptr = 0; m_err = 0;
    reset = 1'b0;
  endtask

  initial begin
    int n, bv0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_reset_vals("rst");
    @(posedge clock);
    #2;
    reset = 1'b0;

    set_req(2, 1, 'h3C);
    wait_quiet("rm_mem_timeout", 40);

    dir_abort = 4'b1000; dir_shared = 4'b1000;
    set_req(0, 1, 'h11);
    wait_quiet("rm_wb_timeout", 40);
    dir_abort = '0; dir_shared = '0;

    apply_reset(2);
    done_log.delete();
    for (int i = 0; i < N; i++) set_req(i, 3, 16 * i + 5);
    wait_quiet("inv_timeout", 60);
    chk("inv_count", done_log.size(), 4);
    for (int k = 1; k < done_log.size(); k++) chk("inv_spacing", done_log[k] - done_log[k-1], 4);

    dir_abort = 4'b0110;
    set_req(3, 2, 'h77);
    wait_quiet("wm_abort_timeout", 40);
    dir_abort = '0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("err_sticky", protocol_err, 1);

    apply_reset(1);
    @(negedge clock);
    chk("err_cleared", protocol_err, 0);
    bv0 = bv_cnt;
    set_req(1, 0, 'h55);
    repeat (20) @(posedge clock);
    chk("op00_no_grant", bv_cnt - bv0, 0);
    #2;
    req[1] = 1'b0;

    mem_hold = 1;
    set_req(2, 1, 'h3C);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("mem_reached", mem_req, 1);
    repeat (2) @(negedge clock);
    done_log.delete();
    @(posedge clock);
    #2;
    reset = 1'b1;
    req   = '0;
    @(posedge clock);
    @(negedge clock);
    chk_reset_vals("rst_mem");
    @(posedge clock);
    #2;
    bq.delete(); dq.delete();
    m_ptr = 0; m_err = 0; mem_hold = 0;
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("no_done_after_reset", done_log.size(), 0);

    @(posedge clock);
    #2;
    snoop_rand = 1;
    rand_en    = 1;
    repeat (3000) @(posedge clock);
    #2;
    rand_en = 0;
    for (int i = 0; i < N; i++) if (req_op[2*i +: 2] == 2'b00) req[i] = 1'b0;
    wait_quiet("drain_timeout", 300);
    chk("queues_empty", bq.size() + dq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
